// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - sync, debounce and press-pulse front-end for the panel push-buttons.
// Optional auto-repeat on REPEAT_MASK keys is built when KEY_REPEAT_EN is defined.
module key_conditioner #(
  parameter int                  NUM_KEYS        = 4,
  parameter int                  DB_CYCLES       = 2_000_000,
  parameter bit                  KEY_ACTIVE_HIGH = 1'b1,
  parameter int                  REPEAT_DELAY    = 50_000_000,
  parameter int                  REPEAT_PERIOD   = 10_000_000,
  parameter logic [NUM_KEYS-1:0] REPEAT_MASK     = NUM_KEYS'(4'b0100)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic [NUM_KEYS-1:0] key_pulse,
  output logic [NUM_KEYS-1:0] key_level,
  output logic                key_any
);

  if (DB_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 ||
      $bits(REPEAT_MASK) != NUM_KEYS) begin : g_bad_params
    $error("key_conditioner: illegal parameter set");
  end

  localparam int              CW       = $clog2(DB_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DB_CYCLES - 1);
  localparam logic [NUM_KEYS-1:0] RELEASED = {NUM_KEYS{~KEY_ACTIVE_HIGH}};

  typedef enum logic [2:0] {
    S_LOCK,
    S_UP,
    S_DN_CHK,
    S_DOWN,
    S_UP_CHK
  } state_t;

  logic [NUM_KEYS-1:0] sync1, sync2, key_s;
  logic [NUM_KEYS-1:0] pulse_d, level_d, rep_pulse;
  state_t              state_q [NUM_KEYS];
  state_t              state_d [NUM_KEYS];
  logic [CW-1:0]       cnt_q   [NUM_KEYS];
  logic [CW-1:0]       cnt_d   [NUM_KEYS];

  // Synchronisers reset to the released level so reset never looks like a press.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= RELEASED;
      sync2 <= RELEASED;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
    end
  end

  assign key_s = KEY_ACTIVE_HIGH ? sync2 : ~sync2;

  always_comb begin
    pulse_d = '0;
    level_d = key_level;
    for (int i = 0; i < NUM_KEYS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        S_LOCK: begin
          if (key_s[i]) begin
            cnt_d[i] = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = S_UP;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
        S_UP: begin
          if (key_s[i]) begin
            state_d[i] = S_DN_CHK;
            cnt_d[i]   = '0;
          end
        end
        S_DN_CHK: begin
          if (!key_s[i]) begin
            state_d[i] = S_UP;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = S_DOWN;
            pulse_d[i] = 1'b1;
            level_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
        S_DOWN: begin
          if (!key_s[i]) begin
            state_d[i] = S_UP_CHK;
            cnt_d[i]   = '0;
          end else begin
            pulse_d[i] = rep_pulse[i];
          end
        end
        S_UP_CHK: begin
          if (key_s[i]) begin
            state_d[i] = S_DOWN;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = S_UP;
            level_d[i] = 1'b0;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
        default: begin
          state_d[i] = S_LOCK;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_pulse <= '0;
      key_level <= '0;
      key_any   <= 1'b0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        state_q[i] <= S_LOCK;
        cnt_q[i]   <= '0;
      end
    end else begin
      key_pulse <= pulse_d;
      key_level <= level_d;
      key_any   <= |key_level;
      for (int i = 0; i < NUM_KEYS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

`ifdef KEY_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HW      = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;
  localparam logic [HW-1:0] DELAY_LAST  = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0] PERIOD_LAST = HW'(REPEAT_PERIOD - 1);

  logic [HW-1:0]       hold_q [NUM_KEYS];
  logic [NUM_KEYS-1:0] rep_phase_q;

  // Phase 0 waits out the initial delay; phase 1 times the steady repeat period.
  always_comb begin
    rep_pulse = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      rep_pulse[i] = REPEAT_MASK[i] &&
                     (rep_phase_q[i] ? (hold_q[i] == PERIOD_LAST) : (hold_q[i] == DELAY_LAST));
    end
  end

  // Counter runs only while held in S_DOWN, freezes through S_UP_CHK, clears elsewhere.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (!rst_n || !REPEAT_MASK[i]) begin
        hold_q[i]      <= '0;
        rep_phase_q[i] <= 1'b0;
      end else if (state_q[i] == S_DOWN) begin
        if (key_s[i]) begin
          if (rep_pulse[i]) begin
            hold_q[i]      <= '0;
            rep_phase_q[i] <= 1'b1;
          end else begin
            hold_q[i] <= hold_q[i] + HW'(1);
          end
        end
      end else if (state_q[i] != S_UP_CHK) begin
        hold_q[i]      <= '0;
        rep_phase_q[i] <= 1'b0;
      end
    end
  end
`else
  assign rep_pulse = '0;
`endif

endmodule

// File: doc/key_conditioner.md
Name: key_conditioner

Overview:
- Front-end for the four push-buttons that drive the main control FSM (bit0 OK, bit1 BACK, bit2 NEXT, bit3 QUICK_MENU).
- Synchronises each raw button, debounces it with a per-key state machine, and emits a single-cycle press pulse per confirmed press.
- key_pulse connects directly to the control FSM key input; key_level is a clean held-level view for display and diagnostics.

Parameters:
- NUM_KEYS, 4, number of independent buttons.
- DB_CYCLES, 2_000_000, debounce window in clk cycles (20 ms at 100 MHz); must be ≥2.
- KEY_ACTIVE_HIGH, 1, raw polarity: 1 = pressed reads high, 0 = pressed reads low.
- REPEAT_DELAY, 50_000_000, hold time before the first auto-repeat pulse (only with KEY_REPEAT_EN).
- REPEAT_PERIOD, 10_000_000, spacing of subsequent auto-repeat pulses (only with KEY_REPEAT_EN).
- REPEAT_MASK, 4'b0100, keys eligible for auto-repeat (default NEXT only).

Ports:
- clk  input  1  system clock, 100 MHz.
- rst_n  input  1  reset, synchronous, active-low.
- key_raw  input  NUM_KEYS  asynchronous button pins.
- key_pulse  output  NUM_KEYS  one-cycle pulse per confirmed press (and per repeat).
- key_level  output  NUM_KEYS  debounced pressed level, 1 = pressed.
- key_any  output  1  OR of key_level.

Behaviour:
- Clocking and reset: one clock domain. Reset is synchronous, active-low, sampled on the rising edge of clk.
- Reset values:
  - key_pulse, key_level, key_any = 0.
  - Synchroniser flops = released level.
  - All per-key counters = 0.
  - Per-key state = S_LOCK.
- Synchronisation: two-flop synchroniser per key, then polarity normalisation to "pressed = 1" (key_s).
- Per-key FSM, counter cnt sized to hold DB_CYCLES-1:
  - S_LOCK: waits for key_s = 0 held DB_CYCLES consecutive cycles, then goes to S_UP. Any key_s = 1 clears cnt. No pulse is ever emitted from S_LOCK, so a button held through reset never produces a press.
  - S_UP: if key_s = 1, go to S_DN_CHK with cnt = 0.
  - S_DN_CHK:
    - key_s = 0 → S_UP (bounce rejected, no pulse).
    - cnt == DB_CYCLES-1 → S_DOWN, key_pulse[i] = 1 for exactly one cycle, key_level[i] = 1.
    - otherwise cnt += 1.
  - S_DOWN: if key_s = 0, go to S_UP_CHK with cnt = 0.
  - S_UP_CHK:
    - key_s = 1 → S_DOWN (release bounce, no new pulse).
    - cnt == DB_CYCLES-1 → S_UP, key_level[i] = 0.
    - otherwise cnt += 1.
- Latency: raw input stable and pressed before edge 0 → key_pulse rises after edge DB_CYCLES+2 and is high for one cycle. The same latency applies to key_level falling on release.
- Keys are fully independent:
  - Simultaneous presses produce simultaneous pulses in the same cycle.
  - No priority or masking is applied here; the control FSM arbitrates.
- Reset asserted mid-operation: reset wins on that edge, all keys return to S_LOCK, and any pending pulse is dropped.
- key_pulse is registered, is never high for two consecutive cycles on the same bit, and never asserts while that key's state is S_UP_CHK or S_LOCK.
- key_any is registered and equals the OR of key_level, delayed by one cycle.

Optional Feature:
- Macro: KEY_REPEAT_EN.
- With the macro defined:
  - Each key with REPEAT_MASK[i] = 1 has a hold counter that starts at 0 on entry to S_DOWN.
  - When the count reaches REPEAT_DELAY-1, the key emits a one-cycle pulse, then one more pulse every REPEAT_PERIOD cycles while it remains in S_DOWN.
  - Entering S_UP_CHK freezes the counter.
  - Returning to S_DOWN from S_UP_CHK resumes the count without emitting a new press pulse.
  - Entering S_UP clears the counter.
- Without the macro: no hold counters are synthesised, and exactly one pulse is emitted per confirmed press regardless of hold time.

Test Plan:
Bench runs with DB_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5.
1. Clean press: after reset, key_raw = 0 for 10 cycles, then key_raw[0] = 1 held → key_pulse = 4'b0001 for exactly one cycle, rising after edge 6 counted from the first high sample; key_level[0] = 1; key_any = 1 one cycle later.
2. Bounce rejection: key_raw[2] toggles 1,1,0,1,0 (each value held one cycle), then stays 0 → no key_pulse and key_level = 0 throughout. Release bounce during hold (1 → 0 for 2 cycles → 1) → no second pulse.
3. Held through reset: key_raw[1] = 1 while rst_n = 0 and for 50 cycles after release → key_pulse[1] never asserts. Then release for 4+ cycles and press again → one pulse.
4. Simultaneous: key_raw = 4'b1001 asserted on the same edge → key_pulse = 4'b1001 in a single cycle.
5. Mid-operation reset: assert rst_n = 0 for 1 cycle while key 0 is in S_DN_CHK with cnt = 2 → no pulse follows; all outputs are 0 on the next cycle.
6. With KEY_REPEAT_EN, hold key 2 for 40 cycles after its press pulse → additional pulses at hold counts 19, 24, 29, 34, 39. With the same hold on key 0 (masked out) → exactly one pulse.
